// File: rtl/timer_pkg.sv
// Shared types and constants for the M:SS countdown timer and the mode FSM
// that feeds it presets.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SEC_UNIT_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Preset digits {minutes, seconds tens, seconds units} driven by the mode FSM
    localparam logic [3:0] PRESET_30S_D0 = 4'd0;
    localparam logic [3:0] PRESET_30S_D1 = 4'd3;
    localparam logic [3:0] PRESET_30S_D2 = 4'd0;
    localparam logic [3:0] PRESET_60S_D0 = 4'd0;
    localparam logic [3:0] PRESET_60S_D1 = 4'd0;
    localparam logic [3:0] PRESET_60S_D2 = 4'd1;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] val, input logic [3:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter; wraps 0 -> MAX and raises a borrow to the
// next more significant digit on the same decrement.
module bcd_down_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    output logic [3:0] value,
    output logic       borrow_out
);

    logic [3:0] r_value;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_value <= 4'd0;
        end else if (load) begin
            r_value <= load_val;
        end else if (dec_en) begin
            r_value <= (r_value == 4'd0) ? MAX : r_value - 4'd1;
        end
    end

    assign value      = r_value;
    assign borrow_out = dec_en && (r_value == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// M:SS countdown timer: clamps and loads a BCD preset, counts down one second
// per tick while running, and flags done at 0:00.
//
// state    | meaning
// ST_IDLE  | preset loaded (or reset), waiting for start
// ST_RUN   | decrementing on each tick
// ST_PAUSE | count frozen, start_stop resumes
// ST_DONE  | reached 0:00, only load or reset leaves
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_MAX = 9
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       tick,
    input  logic       load,
    input  logic       start_stop,
    input  logic [3:0] mode_value_digit0,
    input  logic [3:0] mode_value_digit1,
    input  logic [3:0] mode_value_digit2,
    output logic [3:0] count_digit0,
    output logic [3:0] count_digit1,
    output logic [3:0] count_digit2,
    output logic       running,
    output logic       done
);

    localparam logic [3:0] MIN_LIMIT = 4'(MIN_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_running;
    logic       r_done;
    logic       w_dec;
    logic       w_borrow0;
    logic       w_borrow1;
    logic       w_borrow2;
    logic       w_at_one;
    logic       w_is_zero;
    logic [3:0] w_d0;
    logic [3:0] w_d1;
    logic [3:0] w_d2;

    // A start_stop in the same cycle as a tick wins, so that tick is dropped.
    assign w_dec = (r_state == ST_RUN) && tick && !start_stop && !load;

    bcd_down_digit #(.MAX(SEC_UNIT_MAX)) u_digit0 (
        .clk        (clk),
        .rst_p      (rst_p),
        .load       (load),
        .load_val   (bcd_clamp(mode_value_digit0, SEC_UNIT_MAX)),
        .dec_en     (w_dec),
        .value      (w_d0),
        .borrow_out (w_borrow0)
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_digit1 (
        .clk        (clk),
        .rst_p      (rst_p),
        .load       (load),
        .load_val   (bcd_clamp(mode_value_digit1, SEC_TENS_MAX)),
        .dec_en     (w_borrow0),
        .value      (w_d1),
        .borrow_out (w_borrow1)
    );

    // Never borrows out: RUN is never held at 0:00.
    bcd_down_digit #(.MAX(MIN_LIMIT)) u_digit2 (
        .clk        (clk),
        .rst_p      (rst_p),
        .load       (load),
        .load_val   (bcd_clamp(mode_value_digit2, MIN_LIMIT)),
        .dec_en     (w_borrow1),
        .value      (w_d2),
        .borrow_out (w_borrow2)
    );

    assign w_at_one  = (w_d2 == 4'd0) && (w_d1 == 4'd0) && (w_d0 == 4'd1);
    assign w_is_zero = (w_d2 == 4'd0) && (w_d1 == 4'd0) && (w_d0 == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start_stop && !w_is_zero) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (start_stop)            w_state_nxt = ST_PAUSE;
                    else if (tick && w_at_one) w_state_nxt = ST_DONE;
                end
                ST_PAUSE: if (start_stop) w_state_nxt = ST_RUN;
                ST_DONE:  w_state_nxt = ST_DONE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    assign count_digit0 = w_d0;
    assign count_digit1 = w_d1;
    assign count_digit2 = w_d2;
    assign running      = r_running;
    assign done         = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios then random traffic, all
// compared against a seconds-based reference model.
module tb_countdown_timer;

    localparam int MIN_MAX = 9;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_p = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic       start_stop = 1'b0;
    logic [3:0] d0 = 4'd0;
    logic [3:0] d1 = 4'd0;
    logic [3:0] d2 = 4'd0;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
    logic       running;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int m_secs   = 0;
    int m_state  = M_IDLE;

    countdown_timer #(.MIN_MAX(MIN_MAX)) dut (
        .clk               (clk),
        .rst_p             (rst_p),
        .tick              (tick),
        .load              (load),
        .start_stop        (start_stop),
        .mode_value_digit0 (d0),
        .mode_value_digit1 (d1),
        .mode_value_digit2 (d2),
        .count_digit0      (c0),
        .count_digit1      (c1),
        .count_digit2      (c2),
        .running           (running),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference: count held as total seconds, state as a plain integer.
    task automatic model_step(input bit r, input bit l, input bit s, input bit t,
                              input int p0, input int p1, input int p2);
        if (r) begin
            m_secs  = 0;
            m_state = M_IDLE;
        end else if (l) begin
            m_secs  = clampi(p2, MIN_MAX) * 60 + clampi(p1, 5) * 10 + clampi(p0, 9);
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE:  if (s && m_secs != 0) m_state = M_RUN;
                M_RUN: begin
                    if (s) m_state = M_PAUSE;
                    else if (t) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) m_state = M_DONE;
                    end
                end
                M_PAUSE: if (s) m_state = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit l, input bit s, input bit t,
                        input int p0, input int p1, input int p2);
        @(negedge clk);
        rst_p      = r;
        load       = l;
        start_stop = s;
        tick       = t;
        d0         = 4'(p0);
        d1         = 4'(p1);
        d2         = 4'(p2);
        @(posedge clk);
        model_step(r, l, s, t, p0, p1, p2);
        #1;
        check_val("cnt_d0",  32'(c0), 32'(m_secs % 10));
        check_val("cnt_d1",  32'(c1), 32'((m_secs % 60) / 10));
        check_val("cnt_d2",  32'(c2), 32'(m_secs / 60));
        check_val("running", 32'(running), 32'(m_state == M_RUN));
        check_val("done",    32'(done), 32'(m_state == M_DONE));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        check_val("reset_zero", 32'({c2, c1, c0}), 32'h000);
        step(0, 0, 0, 1, 0, 0, 0);

        // 0:30 down to done, then one extra tick
        step(0, 1, 0, 0, 0, 3, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        ticks(30);
        check_val("t30_done", 32'(done), 32'd1);
        check_val("t30_run",  32'(running), 32'd0);
        ticks(1);
        check_val("t31_zero", 32'({c2, c1, c0}), 32'h000);

        // 1:00 -> 0:59 -> done after 60 ticks
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        ticks(1);
        check_val("t1_059", 32'({c2, c1, c0}), 32'h059);
        ticks(59);
        check_val("t60_done", 32'(done), 32'd1);

        // pause holds, resume continues
        step(0, 1, 0, 0, 0, 3, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        ticks(5);
        step(0, 0, 1, 0, 0, 0, 0);
        ticks(3);
        check_val("pause_025", 32'({c2, c1, c0}), 32'h025);
        step(0, 0, 1, 0, 0, 0, 0);
        ticks(1);
        check_val("resume_024", 32'({c2, c1, c0}), 32'h024);

        // tick and start_stop together: pause wins, no decrement
        step(0, 0, 1, 1, 0, 0, 0);
        check_val("tick_ss_024", 32'({c2, c1, c0}), 32'h024);
        step(0, 1, 0, 0, 0, 0, 1);
        check_val("reload_100", 32'({c2, c1, c0}), 32'h100);

        // clamp
        step(0, 1, 0, 0, 15, 7, 12);
        check_val("clamp_959", 32'({c2, c1, c0}), 32'h959);

        // start at 0:00 ignored; reset mid-run
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check_val("zero_start_idle", 32'(running), 32'd0);
        step(0, 1, 0, 0, 0, 2, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        ticks(3);
        check_val("at_017", 32'({c2, c1, c0}), 32'h017);
        step(1, 0, 1, 1, 0, 0, 0);
        check_val("rst_mid_run", 32'({c2, c1, c0, 3'b000, running, 3'b000, done}), 32'h00000);

        // random traffic; preset digits wiggle every cycle
        for (int i = 0; i < 4000; i++) begin
            bit r, l, s, t;
            int p0, p1, p2;
            r  = ($urandom_range(0, 299) == 0);
            l  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 9) == 0);
            t  = ($urandom_range(0, 1) == 0);
            p0 = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                p1 = $urandom_range(0, 1);
                p2 = 0;
            end else begin
                p1 = $urandom_range(0, 15);
                p2 = $urandom_range(0, 15);
            end
            step(r, l, s, t, p0, p1, p2);
        end

        step(0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
